// File: rtl/aes_axis_slave_packer_pkg.sv
// Shared constants, FSM states and sizing helpers for the AXI-Stream block packer.
package aes_axis_slave_packer_pkg;

  localparam int WORD_S = 32;
  localparam int BLK_S  = 128;
  localparam int Nb     = BLK_S / WORD_S;

  typedef enum logic [1:0] {
    GET_CMD     = 2'd0,
    GET_PAYLOAD = 2'd1,
    WAIT_DONE   = 2'd2
  } state_t;

  function automatic int beats_f(input int blk_w, input int bus_w);
    return blk_w / bus_w;
  endfunction

  // A single-beat block still needs a one-bit counter.
  function automatic int cnt_w_f(input int beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/aes_axis_slave_packer_if.sv
// AXI-Stream slave bus bundle between the DMA stream source and the packer.
interface aes_axis_slave_packer_if
  import aes_axis_slave_packer_pkg::*;
#(
  parameter int DATA_W = WORD_S
) ();

  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [DATA_W/8-1:0] tstrb;

  modport master (output tvalid, tlast, tdata, tstrb, input tready);
  modport slave  (input tvalid, tlast, tdata, tstrb, output tready);

endinterface

// File: rtl/aes_axis_slave_packer_fifo.sv
// Block FIFO storing {pad, last, block}; pushes/pops are pre-qualified by the caller.
module aes_axis_slave_packer_fifo
  import aes_axis_slave_packer_pkg::*;
#(
  parameter int DATA_WIDTH = Nb * WORD_S + 2,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en_i) wptr_q <= wptr_q + 1'b1;
      if (rd_en_i) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q];

endmodule

// File: rtl/aes_axis_slave_packer.sv
// AXI-Stream ingress: latches the command beat, packs payload beats into blocks
// and queues them with last/pad sideband for the AES controller.
module aes_axis_slave_packer
  import aes_axis_slave_packer_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = WORD_S,
  parameter int BLK_WIDTH            = BLK_S,
  parameter int CMD_WIDTH            = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int FIFO_ADDR_WIDTH      = 4,
  parameter int ALMOST_FULL_LEVEL    = 14
) (
  input  logic                       s00_axis_aclk,
  input  logic                       s00_axis_aresetn,
  aes_axis_slave_packer_if.slave     s00_axis,
  input  logic                       axis_master_done,
  input  logic                       aes_controller_in_fifo_r_e,
  output logic [CMD_WIDTH-1:0]       axis_cmd,
  output logic                       axis_cmd_valid,
  output logic                       axis_slave_done,
  output logic                       axis_short_pkt,
  output logic [BLK_WIDTH-1:0]       in_fifo_rdata,
  output logic                       in_fifo_rlast,
  output logic                       in_fifo_rpad,
  output logic                       in_fifo_read_tvalid,
  output logic [FIFO_ADDR_WIDTH:0]   in_fifo_level,
  output logic                       in_fifo_almost_full,
  output logic                       in_fifo_empty,
  output logic                       in_fifo_full
);

  localparam int W     = C_S_AXIS_TDATA_WIDTH;
  localparam int BEATS = beats_f(BLK_WIDTH, W);
  localparam int CNT_W = cnt_w_f(BEATS);
  localparam int LVL_W = FIFO_ADDR_WIDTH + 1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic [BLK_WIDTH-1:0]   blk_q, blk_d;
  logic                   wr_pend_q, wr_pend_d, wr_last_q, wr_last_d, wr_pad_q, wr_pad_d;
  logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
  logic                   cmd_valid_q, cmd_valid_d, done_q, done_d, short_q, short_d;
  logic                   run_q;
  logic [LVL_W-1:0]       level_q;
  logic [BLK_WIDTH+1:0]   fifo_rdata;
  logic                   accept, push, pop, full, empty, blk_end, master_clr;
  logic                   unused_tstrb;

  assign unused_tstrb = ^s00_axis.tstrb;

  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  // run_q keeps tready low through reset and the first cycle after release.
  assign s00_axis.tready = run_q && (state_q != WAIT_DONE) && !wr_pend_q && !full;
  assign accept     = s00_axis.tvalid && s00_axis.tready;
  assign push       = wr_pend_q && !full;
  assign pop        = !empty && aes_controller_in_fifo_r_e;
  assign blk_end    = (beat_q == CNT_W'(BEATS - 1));
  assign master_clr = (state_q == WAIT_DONE) && axis_master_done;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    blk_d       = blk_q;
    wr_pend_d   = wr_pend_q && !push;
    wr_last_d   = wr_last_q;
    wr_pad_d    = wr_pad_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    done_d      = done_q;
    short_d     = short_q;
    unique case (state_q)
      GET_CMD: begin
        if (accept) begin
          cmd_d       = s00_axis.tdata[CMD_WIDTH-1:0];
          cmd_valid_d = 1'b1;
          beat_d      = '0;
          if (s00_axis.tlast) begin
            done_d  = 1'b1;
            state_d = WAIT_DONE;
          end else begin
            state_d = GET_PAYLOAD;
          end
        end
      end
      GET_PAYLOAD: begin
        if (accept) begin
          if (beat_q == '0) blk_d = '0;
          blk_d[int'(beat_q)*W +: W] = s00_axis.tdata;
          if (blk_end || s00_axis.tlast) begin
            wr_pend_d = 1'b1;
            wr_last_d = s00_axis.tlast;
            wr_pad_d  = s00_axis.tlast && !blk_end;
            beat_d    = '0;
            if (s00_axis.tlast && !blk_end) short_d = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
          if (s00_axis.tlast) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (axis_master_done) state_d = GET_CMD;
      end
      default: state_d = GET_CMD;
    endcase
    if (push && wr_last_q) done_d = 1'b1;
    // Release by the egress overrides a done being raised in the same cycle.
    if (master_clr) begin
      done_d  = 1'b0;
      short_d = 1'b0;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q     <= GET_CMD;
      beat_q      <= '0;
      blk_q       <= '0;
      wr_pend_q   <= 1'b0;
      wr_last_q   <= 1'b0;
      wr_pad_q    <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      run_q       <= 1'b0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      blk_q       <= blk_d;
      wr_pend_q   <= wr_pend_d;
      wr_last_q   <= wr_last_d;
      wr_pad_q    <= wr_pad_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      done_q      <= done_d;
      short_q     <= short_d;
      run_q       <= 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  aes_axis_slave_packer_fifo #(
    .DATA_WIDTH (BLK_WIDTH + 2),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk_i     (s00_axis_aclk),
    .rst_ni    (s00_axis_aresetn),
    .wr_en_i   (push),
    .wr_data_i ({wr_pad_q, wr_last_q, blk_q}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata)
  );

  assign axis_cmd            = cmd_q;
  assign axis_cmd_valid      = cmd_valid_q;
  assign axis_slave_done     = done_q;
  assign axis_short_pkt      = short_q;
  assign in_fifo_rdata       = empty ? '0 : fifo_rdata[BLK_WIDTH-1:0];
  assign in_fifo_rlast       = !empty && fifo_rdata[BLK_WIDTH];
  assign in_fifo_rpad        = !empty && fifo_rdata[BLK_WIDTH+1];
  assign in_fifo_read_tvalid = !empty;
  assign in_fifo_level       = level_q;
  assign in_fifo_almost_full = (level_q >= LVL_W'(ALMOST_FULL_LEVEL));
  assign in_fifo_empty       = empty;
  assign in_fifo_full        = full;

endmodule
